alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that drives the ALU's operand and opcode interface and consumes its res/zero/Branch results. It accepts one MIPS instruction at a time, reads the register file, issues the 6-bit ALU opcode with operands, and waits a programmable settle time. It then samples the ALU outputs and emits write-back, memory and branch-resolution signals for the datapath.

Parameters:
ALU_LAT, 1, cycles held in WAIT before sampling ALU outputs (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller idle, can accept
instr  in  32  MIPS instruction word
instr_pc  in  32  PC of instr
rs_addr  out  5  regfile read port A (instr[25:21])
rt_addr  out  5  regfile read port B (instr[20:16])
rs_data  in  32  regfile data A, valid in DECODE
rt_data  in  32  regfile data B, valid in DECODE
alu_opcode  out  6  ALU opcode, registered
alu_s1  out  32  ALU operand 1, registered
alu_s2  out  32  ALU operand 2, registered
alu_res  in  32  ALU result
alu_zero  in  1  ALU zero flag
alu_branch  in  1  ALU Branch flag
done  out  1  one-cycle completion pulse
wb_en  out  1  write-back strobe, qualified by done
wb_addr  out  5  destination register
wb_data  out  32  write-back data
mem_rd  out  1  load strobe, qualified by done
mem_wr  out  1  store strobe, qualified by done
mem_addr  out  32  alu_res for LW/SW
mem_wdata  out  32  rt_data for SW
br_taken  out  1  branch/jump taken, qualified by done
br_target  out  32  branch/jump target
illegal  out  1  undecodable instruction, pulse with done
div0  out  1  DIV with rt_data==0, pulse with done

Behaviour:
- Reset: state IDLE. All outputs are 0 except instr_ready=1. Reset mid-operation aborts the instruction with no done pulse.
- FSM: IDLE -> DECODE on instr_valid&&instr_ready. instr and instr_pc are latched. instr_ready=1 only in IDLE.
- DECODE (1 cycle): rs_addr/rt_addr are driven from latched instr. rs_data/rt_data are latched. Go to EXEC, or to CMPL directly for illegal or div0.
- EXEC (1 cycle): alu_opcode/alu_s1/alu_s2 are registered. Go to WAIT.
- WAIT: count ALU_LAT cycles, then go to CMPL. alu_* are held constant throughout.
- CMPL (1 cycle): sample alu_res/alu_zero/alu_branch, assert done plus qualified strobes, then go to IDLE.
- Latency: accept at cycle T gives done at T+3+ALU_LAT.
- Opcode map, R-type op=0, by funct:
  - 20 ADD=00; 22 SUB=01; 18 MULT=02; 1A DIV=03; 2A SLT=04.
  - 00 SLL=05; 02 SRL=06; 03 SRA=07. For shifts, s1=rt and s2=zero-extended shamt.
  - 24 AND=08; 25 OR=09; 26 XOR=0A; 27 NOR=0B.
  - 10 MFHI=18; 12 MFLO=19; 09 JALR=10.
  - Otherwise s1=rs, s2=rt, and wb_addr=rd.
- Opcode map, I-type:
  - 08 ADDI=00 with sign-extended imm. 0A SLTI=04 with sign-extended imm.
  - 0C ANDI=08, 0D ORI=09, 0E XORI=0A, all with zero-extended imm.
  - 0F LUI=0C with s2=zero-extended imm.
  - 23 LW=1B and 2B SW=1C, both with s1=rs and sign-extended imm.
  - 04 BEQ=11 and 05 BNE=11, both with s1=rs and s2=rt.
  - wb_addr=rt.
- Any other opcode/funct: illegal=1, no ALU issue, all strobes 0.
- wb_en: set for arithmetic, logic, shift, LUI, MFHI, MFLO, LW-no (load data returns elsewhere), JALR.
  - wb_en is forced 0 when wb_addr==0.
  - MULT, DIV, SW and branches never write back.
- wb_data: alu_res, except JALR where wb_data=instr_pc+4.
- Branches: BEQ gives br_taken=alu_branch. BNE gives br_taken=!alu_branch. Target is instr_pc+4+(sext(imm)<<2) with 32-bit wrap.
- JALR: br_taken=1, br_target=alu_res.
- div0: DIV with rt_data==0 is not issued to the ALU and pulses div0 with done.
- Done-qualified outputs (wb_en, mem_rd, mem_wr, br_taken, illegal, div0) are 0 outside CMPL. Data outputs hold their last value.

Optional Feature:
- ALU_CTRL_PERF_EN defined:
  - Adds outputs perf_instr (32) and perf_br_taken (32).
  - perf_instr increments on every done. perf_br_taken increments on done&&br_taken.
  - Both counters wrap at 2^32 and are cleared by rst.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then add $3,$1,$2 with rs=5, rt=7, ALU_LAT=1:
  - alu_opcode=00, s1=5, s2=7.
  - Return alu_res=12: done at T+4 with wb_en=1, wb_addr=3, wb_data=12.
- beq and bne with pc=0x100, imm=0xFFFF:
  - alu_branch=1 on beq: br_taken=1, br_target=0x100.
  - alu_branch=1 on bne: br_taken=0.
- div with rt_data=0: no EXEC issue, done and div0=1, wb_en=0. div with rt_data=3: alu_opcode=03.
- addi $0,$1,4: wb_en=0. lw $4,-4($5) with rs=0x20: s2=0xFFFFFFFC, mem_rd=1, mem_addr=alu_res.
- Illegal op=0x3F: illegal=1 with done after 2 cycles. Assert rst during WAIT: no done, instr_ready=1 next cycle.
- With ALU_CTRL_PERF_EN, 10 instructions of which 3 taken branches: perf_instr=10, perf_br_taken=3.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, register-file, ALU and completion signals between the issue controller
// (master) and the surrounding datapath (slave).
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_s1;
  logic [31:0] alu_s2;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_branch;
  logic        done;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal;
  logic        div0;

  modport master (
    input  instr_valid, instr, instr_pc, rs_data, rt_data, alu_res, alu_zero, alu_branch,
    output instr_ready, rs_addr, rt_addr, alu_opcode, alu_s1, alu_s2, done, wb_en, wb_addr,
           wb_data, mem_rd, mem_wr, mem_addr, mem_wdata, br_taken, br_target, illegal, div0
  );

  modport slave (
    output instr_valid, instr, instr_pc, rs_data, rt_data, alu_res, alu_zero, alu_branch,
    input  instr_ready, rs_addr, rt_addr, alu_opcode, alu_s1, alu_s2, done, wb_en, wb_addr,
           wb_data, mem_rd, mem_wr, mem_addr, mem_wdata, br_taken, br_target, illegal, div0
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle MIPS issue controller: IDLE -> DECODE -> EXEC -> WAIT(ALU_LAT) -> CMPL.
// Optional macro ALU_CTRL_PERF_EN adds perf_instr / perf_br_taken counters.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_instr,
  output logic [31:0]       perf_br_taken
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WAIT, S_CMPL} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_instr, r_pc, r_rs, r_rt;
  logic        r_div0;
  logic [3:0]  r_cnt;
  logic [5:0]  r_alu_opcode;
  logic [31:0] r_alu_s1, r_alu_s2;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data, r_mem_addr, r_mem_wdata, r_br_target;

  logic [5:0]  w_op, w_funct, w_opcode;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wb_addr;
  logic [15:0] w_imm;
  logic [31:0] w_sext, w_zext, w_s1, w_s2, w_pc4, w_wb_data, w_br_target;
  logic        w_wr, w_illegal, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_jalr, w_is_div;
  logic        w_div0, w_done, w_br_taken;
  logic        w_unused_zero;

  assign w_op    = r_instr[31:26];
  assign w_rs    = r_instr[25:21];
  assign w_rt    = r_instr[20:16];
  assign w_rd    = r_instr[15:11];
  assign w_shamt = r_instr[10:6];
  assign w_funct = r_instr[5:0];
  assign w_imm   = r_instr[15:0];
  assign w_sext  = {{16{w_imm[15]}}, w_imm};
  assign w_zext  = {16'h0000, w_imm};
  assign w_pc4   = r_pc + 32'd4;
  assign w_unused_zero = bus.alu_zero;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_opcode  = 6'h00;
    w_s1      = r_rs;
    w_s2      = r_rt;
    w_wb_addr = w_rd;
    w_wr      = 1'b0;
    w_illegal = 1'b0;
    w_is_lw   = 1'b0;
    w_is_sw   = 1'b0;
    w_is_beq  = 1'b0;
    w_is_bne  = 1'b0;
    w_is_jalr = 1'b0;
    w_is_div  = 1'b0;
    if (w_op == 6'h00) begin
      unique case (w_funct)
        6'h20: begin w_opcode = 6'h00; w_wr = 1'b1; end
        6'h22: begin w_opcode = 6'h01; w_wr = 1'b1; end
        6'h18:       w_opcode = 6'h02;
        6'h1A: begin w_opcode = 6'h03; w_is_div = 1'b1; end
        6'h2A: begin w_opcode = 6'h04; w_wr = 1'b1; end
        6'h00, 6'h02, 6'h03: begin
          w_opcode = (w_funct == 6'h00) ? 6'h05 : (w_funct == 6'h02) ? 6'h06 : 6'h07;
          w_s1 = r_rt;
          w_s2 = {27'd0, w_shamt};
          w_wr = 1'b1;
        end
        6'h24: begin w_opcode = 6'h08; w_wr = 1'b1; end
        6'h25: begin w_opcode = 6'h09; w_wr = 1'b1; end
        6'h26: begin w_opcode = 6'h0A; w_wr = 1'b1; end
        6'h27: begin w_opcode = 6'h0B; w_wr = 1'b1; end
        6'h10: begin w_opcode = 6'h18; w_wr = 1'b1; end
        6'h12: begin w_opcode = 6'h19; w_wr = 1'b1; end
        6'h09: begin w_opcode = 6'h10; w_wr = 1'b1; w_is_jalr = 1'b1; end
        default: w_illegal = 1'b1;
      endcase
    end else begin
      w_wb_addr = w_rt;
      unique case (w_op)
        6'h08: begin w_opcode = 6'h00; w_s2 = w_sext; w_wr = 1'b1; end
        6'h0A: begin w_opcode = 6'h04; w_s2 = w_sext; w_wr = 1'b1; end
        6'h0C: begin w_opcode = 6'h08; w_s2 = w_zext; w_wr = 1'b1; end
        6'h0D: begin w_opcode = 6'h09; w_s2 = w_zext; w_wr = 1'b1; end
        6'h0E: begin w_opcode = 6'h0A; w_s2 = w_zext; w_wr = 1'b1; end
        6'h0F: begin w_opcode = 6'h0C; w_s2 = w_zext; w_wr = 1'b1; end
        6'h23: begin w_opcode = 6'h1B; w_s2 = w_sext; w_is_lw = 1'b1; end
        6'h2B: begin w_opcode = 6'h1C; w_s2 = w_sext; w_is_sw = 1'b1; end
        6'h04: begin w_opcode = 6'h11; w_is_beq = 1'b1; end
        6'h05: begin w_opcode = 6'h11; w_is_bne = 1'b1; end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // rt_data is only valid in DECODE, so the divide-by-zero test reads the live port.
  assign w_div0 = w_is_div && (bus.rt_data == 32'd0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.instr_valid) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_illegal || w_div0) ? S_CMPL : S_EXEC;
      S_EXEC:   w_state_nxt = S_WAIT;
      S_WAIT:   if (r_cnt == LAT_M1) w_state_nxt = S_CMPL;
      S_CMPL:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_instr      <= '0;
      r_pc         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_div0       <= 1'b0;
      r_cnt        <= '0;
      r_alu_opcode <= '0;
      r_alu_s1     <= '0;
      r_alu_s2     <= '0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_br_target  <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: if (bus.instr_valid) begin
          r_instr <= bus.instr;
          r_pc    <= bus.instr_pc;
        end
        S_DECODE: begin
          r_rs   <= bus.rs_data;
          r_rt   <= bus.rt_data;
          r_div0 <= w_div0;
        end
        S_EXEC: begin
          r_alu_opcode <= w_opcode;
          r_alu_s1     <= w_s1;
          r_alu_s2     <= w_s2;
          r_cnt        <= '0;
        end
        S_WAIT: r_cnt <= r_cnt + 4'd1;
        S_CMPL: begin
          r_wb_addr   <= w_wb_addr;
          r_wb_data   <= w_wb_data;
          r_mem_addr  <= bus.alu_res;
          r_mem_wdata <= r_rt;
          r_br_target <= w_br_target;
        end
        default: ;
      endcase
    end
  end

  // Results are shown live during CMPL and held in registers afterwards.
  assign w_done      = (r_state == S_CMPL);
  assign w_wb_data   = w_is_jalr ? w_pc4 : bus.alu_res;
  assign w_br_target = w_is_jalr ? bus.alu_res : w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};
  assign w_br_taken  = (w_is_beq && bus.alu_branch) || (w_is_bne && !bus.alu_branch) || w_is_jalr;

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.rs_addr     = w_rs;
  assign bus.rt_addr     = w_rt;
  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.alu_s1      = r_alu_s1;
  assign bus.alu_s2      = r_alu_s2;
  assign bus.done        = w_done;
  assign bus.wb_en       = w_done && w_wr && (w_wb_addr != 5'd0);
  assign bus.mem_rd      = w_done && w_is_lw;
  assign bus.mem_wr      = w_done && w_is_sw;
  assign bus.br_taken    = w_done && w_br_taken;
  assign bus.illegal     = w_done && w_illegal;
  assign bus.div0        = w_done && r_div0;
  assign bus.wb_addr     = w_done ? w_wb_addr   : r_wb_addr;
  assign bus.wb_data     = w_done ? w_wb_data   : r_wb_data;
  assign bus.mem_addr    = w_done ? bus.alu_res : r_mem_addr;
  assign bus.mem_wdata   = w_done ? r_rt        : r_mem_wdata;
  assign bus.br_target   = w_done ? w_br_target : r_br_target;

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] r_perf_instr, r_perf_br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_instr    <= '0;
      r_perf_br_taken <= '0;
    end else if (w_done) begin
      r_perf_instr <= r_perf_instr + 32'd1;
      if (w_br_taken) r_perf_br_taken <= r_perf_br_taken + 32'd1;
    end
  end

  assign perf_instr    = r_perf_instr;
  assign perf_br_taken = r_perf_br_taken;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed-vector bench for alu_issue_ctrl; expected values are hand-computed per instruction.
module tb_alu_issue_ctrl;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  alu_issue_ctrl_if bus ();

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_instr, perf_br_taken;
  alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_instr(perf_instr), .perf_br_taken(perf_br_taken)
  );
`else
  alu_issue_ctrl #(.ALU_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offers one instruction and returns at the negedge where done is high (or budget expires).
  task automatic run(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rs_v,
                     input logic [31:0] rt_v, input logic [31:0] res, input logic br);
    @(negedge clk);
    check("ready_before", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = ins;
    bus.instr_pc    = pc;
    bus.rs_data     = rs_v;
    bus.rt_data     = rt_v;
    bus.alu_res     = res;
    bus.alu_branch  = br;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.instr_pc    = '0;
    bus.rs_data     = '0;
    bus.rt_data     = '0;
    bus.alu_res     = '0;
    bus.alu_zero    = 1'b0;
    bus.alu_branch  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);
    check("rst_opcode", {26'd0, bus.alu_opcode}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_br_target", bus.br_target, 32'd0);

    // add $3,$1,$2
    run(32'h0022_1820, 32'h0000_0040, 32'd5, 32'd7, 32'd12, 1'b0);
    check("add_latency", lat, 3 + LAT);
    check("add_opcode", {26'd0, bus.alu_opcode}, 32'h00);
    check("add_s1", bus.alu_s1, 32'd5);
    check("add_s2", bus.alu_s2, 32'd7);
    check("add_rs_addr", {27'd0, bus.rs_addr}, 32'd1);
    check("add_rt_addr", {27'd0, bus.rt_addr}, 32'd2);
    check("add_wb_en", {31'd0, bus.wb_en}, 32'd1);
    check("add_wb_addr", {27'd0, bus.wb_addr}, 32'd3);
    check("add_wb_data", bus.wb_data, 32'd12);
    check("add_br_taken", {31'd0, bus.br_taken}, 32'd0);
    @(negedge clk);
    check("add_done_drop", {31'd0, bus.done}, 32'd0);
    check("add_wb_en_drop", {31'd0, bus.wb_en}, 32'd0);
    check("add_wb_data_hold", bus.wb_data, 32'd12);

    // beq $1,$2,-1 at pc 0x100, ALU reports equal
    run(32'h1022_FFFF, 32'h0000_0100, 32'd4, 32'd4, 32'd0, 1'b1);
    check("beq_opcode", {26'd0, bus.alu_opcode}, 32'h11);
    check("beq_taken", {31'd0, bus.br_taken}, 32'd1);
    check("beq_target", bus.br_target, 32'h0000_0100);
    check("beq_wb_en", {31'd0, bus.wb_en}, 32'd0);

    // bne with equal operands: not taken
    run(32'h1422_FFFF, 32'h0000_0100, 32'd4, 32'd4, 32'd0, 1'b1);
    check("bne_eq_taken", {31'd0, bus.br_taken}, 32'd0);

    // bne with different operands: taken, forward offset 8
    run(32'h1422_0008, 32'h0000_0100, 32'd4, 32'd5, 32'd0, 1'b0);
    check("bne_ne_taken", {31'd0, bus.br_taken}, 32'd1);
    check("bne_ne_target", bus.br_target, 32'h0000_0124);

    // div $1,$2 with rt=3
    run(32'h0022_001A, 32'h0, 32'd9, 32'd3, 32'd3, 1'b0);
    check("div_opcode", {26'd0, bus.alu_opcode}, 32'h03);
    check("div_s1", bus.alu_s1, 32'd9);
    check("div_div0", {31'd0, bus.div0}, 32'd0);
    check("div_wb_en", {31'd0, bus.wb_en}, 32'd0);

    // div by zero: skips EXEC, ALU operands stay from previous issue
    run(32'h0022_001A, 32'h0, 32'h55, 32'd0, 32'd0, 1'b0);
    check("div0_latency", lat, 2);
    check("div0_flag", {31'd0, bus.div0}, 32'd1);
    check("div0_wb_en", {31'd0, bus.wb_en}, 32'd0);
    check("div0_s1_hold", bus.alu_s1, 32'd9);

    // addi $0,$1,4
    run(32'h2020_0004, 32'h0, 32'd10, 32'd0, 32'd14, 1'b0);
    check("addi0_s2", bus.alu_s2, 32'd4);
    check("addi0_wb_en", {31'd0, bus.wb_en}, 32'd0);

    // lw $4,-4($5)
    run(32'h8CA4_FFFC, 32'h0, 32'h20, 32'd0, 32'h1C, 1'b0);
    check("lw_opcode", {26'd0, bus.alu_opcode}, 32'h1B);
    check("lw_s1", bus.alu_s1, 32'h20);
    check("lw_s2", bus.alu_s2, 32'hFFFF_FFFC);
    check("lw_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    check("lw_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("lw_mem_addr", bus.mem_addr, 32'h1C);
    check("lw_wb_en", {31'd0, bus.wb_en}, 32'd0);

    // sw $6,8($5)
    run(32'hACA6_0008, 32'h0, 32'h40, 32'hDEAD_BEEF, 32'h48, 1'b0);
    check("sw_opcode", {26'd0, bus.alu_opcode}, 32'h1C);
    check("sw_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
    check("sw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("sw_mem_addr", bus.mem_addr, 32'h48);

    // jalr $31,$1 at pc 0x200
    run(32'h0020_F809, 32'h0000_0200, 32'h400, 32'd0, 32'h400, 1'b0);
    check("jalr_opcode", {26'd0, bus.alu_opcode}, 32'h10);
    check("jalr_taken", {31'd0, bus.br_taken}, 32'd1);
    check("jalr_target", bus.br_target, 32'h400);
    check("jalr_wb_data", bus.wb_data, 32'h204);
    check("jalr_wb_addr", {27'd0, bus.wb_addr}, 32'd31);
    check("jalr_wb_en", {31'd0, bus.wb_en}, 32'd1);

`ifdef ALU_CTRL_PERF_EN
    @(negedge clk);
    check("perf_instr", perf_instr, 32'd10);
    check("perf_br_taken", perf_br_taken, 32'd3);
`endif

    // sll $2,$3,4
    run(32'h0003_1100, 32'h0, 32'h99, 32'h11, 32'h110, 1'b0);
    check("sll_opcode", {26'd0, bus.alu_opcode}, 32'h05);
    check("sll_s1", bus.alu_s1, 32'h11);
    check("sll_s2", bus.alu_s2, 32'd4);
    check("sll_wb_addr", {27'd0, bus.wb_addr}, 32'd2);

    // ori $7,$1,0x8001
    run(32'h3427_8001, 32'h0, 32'h1, 32'd0, 32'h8001, 1'b0);
    check("ori_opcode", {26'd0, bus.alu_opcode}, 32'h09);
    check("ori_s2", bus.alu_s2, 32'h0000_8001);
    check("ori_wb_addr", {27'd0, bus.wb_addr}, 32'd7);

    // illegal opcode 0x3F
    run(32'hFC00_0000, 32'h0, 32'd0, 32'd0, 32'd0, 1'b0);
    check("ill_latency", lat, 2);
    check("ill_flag", {31'd0, bus.illegal}, 32'd1);
    check("ill_wb_en", {31'd0, bus.wb_en}, 32'd0);
    check("ill_mem_rd", {31'd0, bus.mem_rd}, 32'd0);

    // Reset during WAIT aborts with no done pulse
    @(negedge clk);
    bus.instr = 32'h0022_1820;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) lat++;
    end
    check("abort_no_done", lat, 0);

    // Recovery after abort
    run(32'h0022_1820, 32'h0, 32'd20, 32'd22, 32'd42, 1'b0);
    check("recover_latency", lat, 3 + LAT);
    check("recover_wb_data", bus.wb_data, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
